audio_mixer_tdm: RTL and testbench

- Parametrised, time-multiplexed stereo audio mixer. Successor to the fixed top-level sum of the TIA LUT, POKEY and YM outputs, which wraps on overflow.
- Mixes NUM_CH signed sources, each with its own gain and pan, into saturated left/right outputs.
- Sits between the sound sources (TIA, POKEY, YM, future cart audio) and AUDIO_L/AUDIO_R.
- Starts one mix per sample_stb and uses one shared multiplier.

---
 rtl/audio_mixer_pkg.sv | 49 ++++
 rtl/audio_mac.sv | 27 ++
 rtl/audio_mixer_tdm.sv | 189 ++++++++++++++++++
 tb/tb_audio_mixer_tdm.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared types, the TIA volume table and the output clamp
// used by the time-multiplexed stereo mixer (audio_mixer_tdm).
package audio_mixer_pkg;

   // Per-channel routing code as carried on ch_pan.
   typedef enum logic [1:0] {
      PAN_BOTH  = 2'b00,
      PAN_LEFT  = 2'b01,
      PAN_RIGHT = 2'b10,
      PAN_MUTE  = 2'b11
   } pan_e;

   // Mixer sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC  = 2'b01,
      ST_SAT  = 2'b10
   } state_e;

   localparam int TIA_TAB_N = 31;

   // Combined TIA volume (audv0 + audv1) to output level. The curve is
   // monotonic and S-shaped: it rises slowly, is steepest around the middle
   // of the range and compresses towards full scale.
   localparam logic [14:0] TIA_VOL_TABLE [0:TIA_TAB_N-1] = '{
      15'd0,     15'd500,   15'd1050,  15'd1650,  15'd2300,
      15'd3000,  15'd3750,  15'd4550,  15'd5400,  15'd6300,
      15'd7400,  15'd8800,  15'd10900, 15'd14000, 15'd17800,
      15'd21844, 15'd23800, 15'd25400, 15'd26700, 15'd27800,
      15'd28700, 15'd29450, 15'd30100, 15'd30650, 15'd31100,
      15'd31500, 15'd31850, 15'd32150, 15'd32400, 15'd32600,
      15'd32767
   };

   // Clamp a signed value into the range of an out_w-bit signed number.
   // The result is returned sign-extended to 64 bits; callers keep the low
   // out_w bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int                 out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

endpackage

// File: rtl/audio_mac.sv
// audio_mac: combinational signed-sample by unsigned-gain multiply with the
// unity-gain renormalising shift. One instance is shared by all channels.
module audio_mac
   import audio_mixer_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int GAIN_W = 8
) (
   input  logic signed [IN_W-1:0]      sample,
   input  logic        [GAIN_W-1:0]    gain,
   output logic signed [IN_W+GAIN_W:0] product
);

   localparam int PROD_W = IN_W + GAIN_W + 1;

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] gain_ext;

   // Sign-extend the sample, zero-extend the gain so the product is a plain
   // signed multiply; one extra bit of headroom keeps the full product exact.
   assign sample_ext = {{(GAIN_W + 1){sample[IN_W-1]}}, sample};
   assign gain_ext   = {{(IN_W + 1){1'b0}}, gain};

   // 2^(GAIN_W-1) is unity, so dividing by it (flooring) restores the scale.
   assign product = (sample_ext * gain_ext) >>> (GAIN_W - 1);

endmodule

// File: rtl/audio_mixer_tdm.sv
// audio_mixer_tdm: time-multiplexed stereo mixer. Each sample_stb snapshots
// all channel inputs, then one shared multiplier scales one channel per cycle
// into wide left/right accumulators, which are rescaled and clamped into
// audio_l/audio_r.
// Optional build macro AUDIO_TIA_LUT_EN adds the tia_audv0/tia_audv1 ports and
// one extra accumulate cycle that adds the TIA volume table level to both
// sides at unity gain.
module audio_mixer_tdm
   import audio_mixer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 16,
   parameter int GAIN_W = 8,
   parameter int OUT_W  = 16
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       sample_stb,
   input  logic [NUM_CH*IN_W-1:0]     ch_in,
   input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
   input  logic [NUM_CH*2-1:0]        ch_pan,
   input  logic                       overrun_clr,
`ifdef AUDIO_TIA_LUT_EN
   input  logic [3:0]                 tia_audv0,
   input  logic [3:0]                 tia_audv1,
`endif
   output logic signed [OUT_W-1:0]    audio_l,
   output logic signed [OUT_W-1:0]    audio_r,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int PROD_W = IN_W + GAIN_W + 1;
   localparam int ACC_W  = IN_W + GAIN_W + $clog2(NUM_CH + 2) + 1;
   localparam int IDX_W  = $clog2(NUM_CH + 2);
   localparam int SHR    = (IN_W > OUT_W) ? (IN_W - OUT_W) : 0;
   localparam int SHL    = (OUT_W > IN_W) ? (OUT_W - IN_W) : 0;
`ifdef AUDIO_TIA_LUT_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);
`else
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
`endif

   state_e                   state;
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc_l;
   logic signed [ACC_W-1:0]  acc_r;

   logic [NUM_CH*IN_W-1:0]   snap_in;
   logic [NUM_CH*GAIN_W-1:0] snap_gain;
   logic [NUM_CH*2-1:0]      snap_pan;
`ifdef AUDIO_TIA_LUT_EN
   logic [3:0]               snap_audv0;
   logic [3:0]               snap_audv1;
   logic [4:0]               tia_idx;
   logic [14:0]              tia_level;
`endif

   logic signed [IN_W-1:0]   cur_in;
   logic [GAIN_W-1:0]        cur_gain;
   pan_e                     cur_pan;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  addend;
   logic                     add_l;
   logic                     add_r;
   logic signed [OUT_W-1:0]  sat_l;
   logic signed [OUT_W-1:0]  sat_r;

   logic                     start;
   assign start = (state == ST_IDLE) && sample_stb;

   // Capture the channel inputs when a mix starts; the mix only ever reads this copy.
   always_ff @(posedge clk_sys) begin
      if (start) begin
         snap_in   <= ch_in;
         snap_gain <= ch_gain;
         snap_pan  <= ch_pan;
`ifdef AUDIO_TIA_LUT_EN
         snap_audv0 <= tia_audv0;
         snap_audv1 <= tia_audv1;
`endif
      end
   end

   // Select the channel addressed by the accumulate index for the shared MAC.
   always_comb begin
      cur_in   = '0;
      cur_gain = '0;
      cur_pan  = PAN_MUTE;
      for (int k = 0; k < NUM_CH; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_in   = snap_in[k*IN_W +: IN_W];
            cur_gain = snap_gain[k*GAIN_W +: GAIN_W];
            cur_pan  = pan_e'(snap_pan[k*2 +: 2]);
         end
      end
   end

   audio_mac #(
      .IN_W   (IN_W),
      .GAIN_W (GAIN_W)
   ) u_mac (
      .sample  (cur_in),
      .gain    (cur_gain),
      .product (prod)
   );

`ifdef AUDIO_TIA_LUT_EN
   assign tia_idx   = {1'b0, snap_audv0} + {1'b0, snap_audv1};
   assign tia_level = TIA_VOL_TABLE[tia_idx];
`endif

   // Route the scaled sample (or the TIA level in its slot) to either side.
   always_comb begin
      addend = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
      add_l  = (cur_pan == PAN_BOTH) || (cur_pan == PAN_LEFT);
      add_r  = (cur_pan == PAN_BOTH) || (cur_pan == PAN_RIGHT);
`ifdef AUDIO_TIA_LUT_EN
      if (idx == IDX_W'(NUM_CH)) begin
         addend = {{(ACC_W - 15){1'b0}}, tia_level};
         add_l  = 1'b1;
         add_r  = 1'b1;
      end
`endif
   end

   // Rescale the accumulators to the output width and clamp to its signed range.
   always_comb begin
      sat_l = OUT_W'(saturate(($signed({{(64 - ACC_W){acc_l[ACC_W-1]}}, acc_l}) >>> SHR) <<< SHL, OUT_W));
      sat_r = OUT_W'(saturate(($signed({{(64 - ACC_W){acc_r[ACC_W-1]}}, acc_r}) >>> SHR) <<< SHL, OUT_W));
   end

   // Mix sequencer: snapshot, accumulate one slot per cycle, then saturate and publish.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         audio_l   <= '0;
         audio_r   <= '0;
      end else begin
         out_valid <= 1'b0;
         // A strobe that cannot be taken outranks a clear in the same cycle.
         if (overrun_clr)
            overrun <= 1'b0;
         if (sample_stb && (state != ST_IDLE))
            overrun <= 1'b1;

         unique case (state)
            ST_IDLE: begin
               if (sample_stb) begin
                  acc_l <= '0;
                  acc_r <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (add_l)
                  acc_l <= acc_l + addend;
               if (add_r)
                  acc_r <= acc_r + addend;
               if (idx == LAST_IDX)
                  state <= ST_SAT;
               else
                  idx <= idx + 1'b1;
            end
            ST_SAT: begin
               audio_l   <= sat_l;
               audio_r   <= sat_r;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// tb_audio_mixer_tdm: scoreboard bench for audio_mixer_tdm. Expected outputs
// are computed from the driven inputs at each accepted strobe and compared
// when out_valid pulses. Build with AUDIO_TIA_LUT_EN to cover the TIA slot.
module tb_audio_mixer_tdm;

   localparam int NUM_CH = 4;
   localparam int IN_W   = 16;
   localparam int GAIN_W = 8;
   localparam int OUT_W  = 16;
`ifdef AUDIO_TIA_LUT_EN
   localparam int LAT = NUM_CH + 3;
`else
   localparam int LAT = NUM_CH + 2;
`endif

   logic                      clk_sys;
   logic                      reset;
   logic                      sample_stb;
   logic [NUM_CH*IN_W-1:0]    ch_in;
   logic [NUM_CH*GAIN_W-1:0]  ch_gain;
   logic [NUM_CH*2-1:0]       ch_pan;
   logic                      overrun_clr;
`ifdef AUDIO_TIA_LUT_EN
   logic [3:0]                tia_audv0;
   logic [3:0]                tia_audv1;
`endif
   logic signed [OUT_W-1:0]   audio_l;
   logic signed [OUT_W-1:0]   audio_r;
   logic                      out_valid;
   logic                      busy;
   logic                      overrun;

   audio_mixer_tdm #(
      .NUM_CH (NUM_CH),
      .IN_W   (IN_W),
      .GAIN_W (GAIN_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .sample_stb  (sample_stb),
      .ch_in       (ch_in),
      .ch_gain     (ch_gain),
      .ch_pan      (ch_pan),
      .overrun_clr (overrun_clr),
`ifdef AUDIO_TIA_LUT_EN
      .tia_audv0   (tia_audv0),
      .tia_audv1   (tia_audv1),
`endif
      .audio_l     (audio_l),
      .audio_r     (audio_r),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      int l;
      int r;
      int due;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   nvalid = 0;

   task automatic check_val(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference mix of the inputs currently driven.
   function automatic void model(output int l, output int r);
      longint sl;
      longint sr;
      longint p;
      sl = 0;
      sr = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         p = (longint'($signed(ch_in[k*IN_W +: IN_W])) *
              longint'(ch_gain[k*GAIN_W +: GAIN_W])) >>> (GAIN_W - 1);
         case (ch_pan[k*2 +: 2])
            2'b00: begin sl += p; sr += p; end
            2'b01: sl += p;
            2'b10: sr += p;
            default: ;
         endcase
      end
`ifdef AUDIO_TIA_LUT_EN
      case (int'(tia_audv0) + int'(tia_audv1))
         15:      begin sl += 21844; sr += 21844; end
         30:      begin sl += 32767; sr += 32767; end
         default: ;
      endcase
`endif
      if (sl > 32767) sl = 32767;
      if (sl < -32768) sl = -32768;
      if (sr > 32767) sr = 32767;
      if (sr < -32768) sr = -32768;
      l = int'(sl);
      r = int'(sr);
   endfunction

   // Compare each published mix against the oldest outstanding expectation.
   always @(negedge clk_sys) begin : monitor
      exp_t e;
      if (out_valid === 1'b1) begin
         nvalid++;
         if (sb.size() == 0) begin
            check_val("spurious_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check_val("latency", cyc, e.due);
            check_val("audio_l", audio_l, e.l);
            check_val("audio_r", audio_r, e.r);
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear_inputs();
      ch_in   = '0;
      ch_gain = '0;
      ch_pan  = '0;
`ifdef AUDIO_TIA_LUT_EN
      tia_audv0 = 4'd0;
      tia_audv1 = 4'd0;
`endif
   endtask

   task automatic set_ch(input int k, input logic [15:0] v, input logic [7:0] g,
                         input logic [1:0] p);
      ch_in[k*IN_W +: IN_W]       = v;
      ch_gain[k*GAIN_W +: GAIN_W] = g;
      ch_pan[k*2 +: 2]            = p;
   endtask

   // One-cycle strobe with the expectation queued; returns one cycle later.
   task automatic start_mix();
      exp_t e;
      int   l;
      int   r;
      model(l, r);
      e.l   = l;
      e.r   = r;
      e.due = cyc + LAT;
      sb.push_back(e);
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         check_val("timeout_pending", sb.size(), 0);
         sb.delete();
      end
      tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int nv0;
      reset       = 1'b1;
      sample_stb  = 1'b0;
      overrun_clr = 1'b0;
      clear_inputs();
      repeat (3) tick();
      check_val("rst_audio_l", audio_l, 0);
      check_val("rst_audio_r", audio_r, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_overrun", overrun, 0);
      reset = 1'b0;
      tick();

      // Unity gain, centre pan; inputs scrambled after the strobe.
      clear_inputs();
      set_ch(0, 16'h1000, 8'h80, 2'b00);
      start_mix();
      check_val("busy_during_mix", busy, 1);
      ch_in   = {$urandom(), $urandom()};
      ch_gain = $urandom();
      wait_done();
      check_val("unity_l", audio_l, 16'sh1000);
      check_val("unity_r", audio_r, 16'sh1000);
      check_val("idle_busy", busy, 0);

      // Half gain, left only / right only / mute.
      clear_inputs();
      set_ch(1, 16'h2000, 8'h40, 2'b01);
      start_mix();
      wait_done();
      check_val("pan_left_l", audio_l, 16'sh1000);
      check_val("pan_left_r", audio_r, 0);
      set_ch(1, 16'h2000, 8'h40, 2'b10);
      start_mix();
      wait_done();
      check_val("pan_right_l", audio_l, 0);
      check_val("pan_right_r", audio_r, 16'sh1000);
      set_ch(1, 16'h2000, 8'h40, 2'b11);
      start_mix();
      wait_done();
      check_val("pan_mute_l", audio_l, 0);
      check_val("pan_mute_r", audio_r, 0);

      // Positive and negative saturation.
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h7000, 8'h80, 2'b00);
      start_mix();
      wait_done();
      check_val("sat_pos_l", audio_l, 32767);
      check_val("sat_pos_r", audio_r, 32767);
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h9000, 8'h80, 2'b00);
      start_mix();
      wait_done();
      check_val("sat_neg_l", audio_l, -32768);
      check_val("sat_neg_r", audio_r, -32768);

      // Overrun: second strobe two cycles in is ignored.
      clear_inputs();
      set_ch(2, 16'h0123, 8'h80, 2'b00);
      nv0 = nvalid;
      start_mix();
      set_ch(3, 16'h4000, 8'h80, 2'b00);
      tick();
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      wait_done();
      repeat (6) tick();
      check_val("overrun_one_valid", nvalid - nv0, 1);
      check_val("overrun_set", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check_val("overrun_cleared", overrun, 0);
      // Set and clear in the same cycle: set wins.
      start_mix();
      tick();
      sample_stb  = 1'b1;
      overrun_clr = 1'b1;
      tick();
      sample_stb  = 1'b0;
      overrun_clr = 1'b0;
      check_val("overrun_set_wins", overrun, 1);
      wait_done();

      // Reset two cycles into a mix aborts it.
      clear_inputs();
      set_ch(0, 16'h1000, 8'h80, 2'b00);
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check_val("midrst_audio_l", audio_l, 0);
      check_val("midrst_audio_r", audio_r, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_overrun", overrun, 0);
      tick();
      reset = 1'b0;
      nv0 = nvalid;
      repeat (12) tick();
      check_val("midrst_no_valid", nvalid - nv0, 0);

      // Random mixes.
      for (int i = 0; i < 10; i++) begin
         clear_inputs();
         ch_in   = {$urandom(), $urandom()};
         ch_gain = $urandom();
         ch_pan  = 8'($urandom());
         start_mix();
         wait_done();
      end

`ifdef AUDIO_TIA_LUT_EN
      // TIA slot at full and mid volume, no channel contribution.
      clear_inputs();
      tia_audv0 = 4'd15;
      tia_audv1 = 4'd15;
      start_mix();
      wait_done();
      check_val("tia_full_l", audio_l, 32767);
      check_val("tia_full_r", audio_r, 32767);
      tia_audv1 = 4'd0;
      start_mix();
      wait_done();
      check_val("tia_mid_l", audio_l, 16'sh5554);
      check_val("tia_mid_r", audio_r, 16'sh5554);
      clear_inputs();
`endif

      repeat (4) tick();
      check_val("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
